seq_add_sub: RTL and testbench

SEQ_ADD_SUB -- requirements
Module: seq_add_sub

---
 rtl/seq_add_sub.sv | 116 +++++++++++
 tb/tb_seq_add_sub.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_add_sub.sv
// Chunk-serial adder/subtractor: one CHUNK-bit slice per cycle, LSB slice first,
// with a registered ripple carry between slices.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one slice added per cycle, busy=1
// DONE  | out/ovf valid, done=1 for this single cycle
module seq_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   out,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if ((WIDTH % CHUNK) != 0 || N < 1) begin : g_bad_params
      $error("seq_add_sub: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;
  logic             msb_cin;

  always_comb begin
    sum     = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    // sum bit = a ^ b ^ carry_in, so the carry into the slice MSB falls out directly
    msb_cin = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ sum[CHUNK-1];
  end

  // a_q doubles as the result register: each sum slice enters at the top
  // while the consumed operand slice leaves at the bottom.
  generate
    if (N == 1) begin : g_single
      assign a_next = sum[CHUNK-1:0];
      assign b_next = b_q;
    end else begin : g_multi
      assign a_next = {sum[CHUNK-1:0], a_q[WIDTH-1:CHUNK]};
      assign b_next = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      out   <= '0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            a_q   <= in1;
            b_q   <= sub ? ~in2 : in2;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_next;
          b_q   <= b_next;
          carry <= sum[CHUNK];
          if (cnt == LAST) begin
            out   <= {sum[CHUNK], a_next};
            ovf   <= msb_cin ^ sum[CHUNK];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_add_sub.sv
// Directed bench for seq_add_sub: scoreboard of expected results pushed at
// start, popped when done pulses; second instance covers the single-chunk case.
module tb_seq_add_sub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [15:0] in1 = '0, in2 = '0;
  logic        busy, done, ovf;
  logic [16:0] out;

  logic        start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  in1_8 = '0, in2_8 = '0;
  logic        busy8, done8, ovf8;
  logic [8:0]  out8;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [17:0] sb[$];
  logic [17:0] last_exp;

  always #5 clk = ~clk;

  seq_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
    .in1(in1), .in2(in2), .busy(busy), .done(done), .out(out), .ovf(ovf)
  );

  seq_add_sub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .cin(cin8),
    .in1(in1_8), .in2(in2_8), .busy(busy8), .done(done8), .out(out8), .ovf(ovf8)
  );

  // returns {ovf, out[16:0]}
  function automatic logic [17:0] model(input logic s, input logic c,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [15:0] bb;
    logic [16:0] r;
    logic        v;
    bb = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {16'd0, (s ? 1'b1 : c)};
    v  = (a[15] == bb[15]) && (r[15] != a[15]);
    return {v, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic s, input logic c, input logic [15:0] a,
                          input logic [15:0] b, input bit push);
    start = 1'b1; sub = s; cin = c; in1 = a; in2 = b;
    if (push) sb.push_back(model(s, c, a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge after the start edge (or later); counts busy cycles
  // until done is seen, then checks the result against the scoreboard head.
  task automatic wait_done(input string tag, output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 30 && done !== 1'b1; i++) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    last_exp = (sb.size() > 0) ? sb.pop_front() : 18'h3ffff;
    chk({tag, "_out"}, {15'd0, out}, {15'd0, last_exp[16:0]});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, last_exp[17]});
  endtask

  task automatic run_op(input string tag, input logic s, input logic c,
                        input logic [15:0] a, input logic [15:0] b);
    int nb;
    do_start(s, c, a, b, 1'b1);
    wait_done(tag, nb);
    chk({tag, "_busy_cycles"}, nb, 32'd4);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    chk({tag, "_out_hold"}, {15'd0, out}, {15'd0, last_exp[16:0]});
  endtask

  initial begin
    int nb;
    bit saw_done;

    repeat (2) @(negedge clk);
    chk("rst_out", {15'd0, out}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    // start presented on the first edge after reset release
    rst = 1'b0;
    run_op("add_ffff_1", 1'b0, 1'b0, 16'hFFFF, 16'h0001);
    chk("add_ffff_1_lit", {15'd0, last_exp[16:0]}, 32'h10000);
    run_op("sub_5_7", 1'b1, 1'b0, 16'h0005, 16'h0007);
    chk("sub_5_7_lit", {15'd0, out}, 32'h0FFFE);
    run_op("sub_7_5", 1'b1, 1'b1, 16'h0007, 16'h0005);
    chk("sub_7_5_lit", {15'd0, out}, 32'h10002);
    run_op("add_7fff_1", 1'b0, 1'b0, 16'h7FFF, 16'h0001);
    chk("add_7fff_1_lit", {14'd0, ovf, out}, {14'd0, 18'h28000});
    run_op("add_0_0_cin", 1'b0, 1'b1, 16'h0000, 16'h0000);
    chk("add_0_0_cin_lit", {15'd0, out}, 32'h00001);

    // start and operand changes while running must be ignored
    do_start(1'b0, 1'b0, 16'h1234, 16'h4321, 1'b1);
    @(negedge clk);
    start = 1'b1; sub = 1'b1; in1 = 16'hAAAA; in2 = 16'h5555; cin = 1'b1;
    @(negedge clk);
    start = 1'b0; in1 = 16'h0F0F; in2 = 16'hF0F0;
    wait_done("midrun", nb);
    chk("midrun_remaining_busy", nb, 32'd2);

    // start during DONE: back-to-back, next done N+1 cycles after this one
    do_start(1'b0, 1'b0, 16'h7FFF, 16'h0001, 1'b1);
    chk("b2b_busy_after_start", {31'd0, busy}, 32'd1);
    chk("b2b_done_dropped", {31'd0, done}, 32'd0);
    wait_done("b2b", nb);
    chk("b2b_gap", nb + 1, 32'd5);

    // reset in the second RUN cycle abandons the operation
    do_start(1'b1, 1'b0, 16'h0100, 16'h0001, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_out", {15'd0, out}, 32'd0);
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);
    run_op("after_abort", 1'b1, 1'b0, 16'h8000, 16'h0001);

    for (int i = 0; i < 6; i++) begin
      run_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'($urandom), 16'($urandom));
    end

    // single-chunk instance
    start8 = 1'b1; in1_8 = 8'hFF; in2_8 = 8'hFF; cin8 = 1'b1; sub8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    chk("n1_busy", {31'd0, busy8}, 32'd1);
    chk("n1_done_early", {31'd0, done8}, 32'd0);
    @(negedge clk);
    chk("n1_busy_end", {31'd0, busy8}, 32'd0);
    chk("n1_done", {31'd0, done8}, 32'd1);
    chk("n1_out", {23'd0, out8}, 32'h1FF);
    chk("n1_ovf", {31'd0, ovf8}, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
